// File: rtl/ifetch_queue.sv
// Fetch stage: issues imem reads at pc, queues in-order responses in reserved slots and
// presents {inst, pc} to decode; flush drops queued entries and counts in-flight responses to discard.
module ifetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   output logic            pc_hold,
   input  logic            flush,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_inst,
   output logic [XLEN-1:0] id_pc
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_fill_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_drop_cnt;
   logic [DEPTH-1:0] r_filled;
   logic [XLEN-1:0] r_slot_pc   [DEPTH];
   logic [XLEN-1:0] r_slot_inst [DEPTH];

   logic [PW-1:0]    w_alloc_cnt;
   logic [PW-1:0]    w_unfilled;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_fill_idx;
   logic [AW-1:0]    w_rd_idx;
   logic             w_full;
   logic             w_empty;
   logic             w_drop_idle;
   logic             w_issue;
   logic             w_fill;
   logic             w_resp_used;
   logic             w_pop;
   logic [DEPTH-1:0] w_filled_next;

   assign w_alloc_cnt = r_wr_ptr - r_rd_ptr;
   assign w_unfilled  = r_wr_ptr - r_fill_ptr;
   assign w_wr_idx    = r_wr_ptr[AW-1:0];
   assign w_fill_idx  = r_fill_ptr[AW-1:0];
   assign w_rd_idx    = r_rd_ptr[AW-1:0];
   assign w_full      = (w_alloc_cnt == DEPTH_P);
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_drop_idle = (r_drop_cnt == '0);

   assign imem_req    = rst & ~flush & ~w_full & w_drop_idle;
   assign imem_addr   = pc;
   assign w_issue     = imem_req & imem_gnt;
   assign pc_hold     = ~w_issue;

   // A response with no reserved slot and nothing to drop is ignored entirely.
   assign w_fill      = imem_rvalid & w_drop_idle & (w_unfilled != '0);
   assign w_resp_used = imem_rvalid & (~w_drop_idle | (w_unfilled != '0));

   assign id_valid    = rst & r_filled[w_rd_idx] & ~w_empty;
   assign w_pop       = id_valid & id_ready;
   assign id_inst     = r_slot_inst[w_rd_idx];
   assign id_pc       = r_slot_pc[w_rd_idx];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
         always_comb begin
            w_filled_next[gi] = r_filled[gi];
            if (w_fill && (w_fill_idx == AW'(gi)))
               w_filled_next[gi] = 1'b1;
            else if (w_pop && (w_rd_idx == AW'(gi)))
               w_filled_next[gi] = 1'b0;
            else if (w_issue && (w_wr_idx == AW'(gi)))
               w_filled_next[gi] = 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_fill_ptr <= '0;
         r_rd_ptr   <= '0;
         r_drop_cnt <= '0;
         r_filled   <= '0;
      end else if (flush) begin
         // Unfilled slots are still in flight; a response arriving now is already accounted for.
         r_wr_ptr   <= '0;
         r_fill_ptr <= '0;
         r_rd_ptr   <= '0;
         r_drop_cnt <= r_drop_cnt + w_unfilled - PW'(w_resp_used);
         r_filled   <= '0;
      end else begin
         if (w_issue) r_wr_ptr   <= r_wr_ptr + 1'b1;
         if (w_fill)  r_fill_ptr <= r_fill_ptr + 1'b1;
         if (w_pop)   r_rd_ptr   <= r_rd_ptr + 1'b1;
         if (!w_drop_idle && imem_rvalid) r_drop_cnt <= r_drop_cnt - 1'b1;
         r_filled <= w_filled_next;
      end
   end

   always_ff @(posedge clk) begin
      if (w_issue) r_slot_pc[w_wr_idx] <= pc;
   end

   always_ff @(posedge clk) begin
      if (w_fill) r_slot_inst[w_fill_idx] <= imem_rdata;
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed and randomized checks of ifetch_queue against an in-order queue model
// with a bench-side PC register and instruction memory.
module tb_ifetch_queue;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, flush, imem_gnt, imem_rvalid, id_ready;
   logic [XLEN-1:0] pc, imem_rdata;
   logic            pc_hold, imem_req, id_valid;
   logic [XLEN-1:0] imem_addr, id_inst, id_pc;

   ifetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .pc(pc), .pc_hold(pc_hold), .flush(flush),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      bit          filled;
   } entry_t;

   entry_t      mq[$];
   int          drop = 0;
   int          mem_cnt = 0;
   int          total = 0;
   int          bad = 0;
   bit          auto_mem = 0;
   int          gnt_pct = 0, rv_pct = 0, rdy_pct = 0;
   bit          seq_data = 0;
   logic [31:0] seq_val = 32'h0;
   logic [31:0] redirect_pc = 32'h0;
   int          grants_obs = 0;
   int          pops = 0;
   int          cyc = 0;
   int          first_valid_cyc = -1;
   logic [31:0] first_pop_pc = 32'hDEAD_BEEF;
   logic [31:0] last_pop_pc = 32'h0;
   bit          last_req_obs = 0;
   bit          last_valid_obs = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      bit e_req, e_issue, e_valid, e_pop;
      int unf, used, idx;
      if (auto_mem) begin
         imem_gnt    = ($urandom_range(99) < gnt_pct);
         imem_rvalid = (mem_cnt > 0) && ($urandom_range(99) < rv_pct);
         id_ready    = ($urandom_range(99) < rdy_pct);
      end
      imem_rdata = seq_data ? seq_val : $urandom;
      @(negedge clk);
      e_req   = rst && !flush && (mq.size() < DEPTH) && (drop == 0);
      e_issue = e_req && imem_gnt;
      e_valid = rst && (mq.size() > 0) && mq[0].filled;
      e_pop   = e_valid && id_ready && !flush;
      chk("imem_req", 32'(imem_req), 32'(e_req));
      chk("pc_hold", 32'(pc_hold), 32'(!e_issue));
      chk("imem_addr", imem_addr, pc);
      chk("id_valid", 32'(id_valid), 32'(e_valid));
      if (e_valid) begin
         chk("id_pc", id_pc, mq[0].pc);
         chk("id_inst", id_inst, mq[0].inst);
      end
      if (imem_req && imem_gnt) grants_obs++;
      if (id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      last_req_obs   = imem_req;
      last_valid_obs = id_valid;
      cyc++;
      @(posedge clk);
      #1;
      if (!rst) begin
         mq.delete();
         drop    = 0;
         mem_cnt = 0;
         pc      = 32'h0;
      end else begin
         if (imem_rvalid && mem_cnt > 0) mem_cnt--;
         if (e_issue) mem_cnt++;
         if (flush) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            used = (imem_rvalid && (drop > 0 || unf > 0)) ? 1 : 0;
            drop = drop + unf - used;
            mq.delete();
            pc = redirect_pc;
         end else begin
            if (imem_rvalid) begin
               if (drop > 0) drop--;
               else begin
                  idx = -1;
                  foreach (mq[i]) if (idx < 0 && !mq[i].filled) idx = i;
                  if (idx >= 0) begin
                     mq[idx].inst   = imem_rdata;
                     mq[idx].filled = 1'b1;
                  end
               end
            end
            if (e_pop) begin
               $display("pop pc=0x%08h inst=0x%08h", mq[0].pc, mq[0].inst);
               if (pops == 0) first_pop_pc = mq[0].pc;
               last_pop_pc = mq[0].pc;
               pops++;
               void'(mq.pop_front());
            end
            if (e_issue) begin
               mq.push_back('{pc: pc, inst: 32'h0, filled: 1'b0});
               pc = pc + 32'd4;
            end
         end
      end
      if (seq_data && imem_rvalid) seq_val = seq_val + 32'd1;
   endtask

   task automatic drain();
      auto_mem = 1; gnt_pct = 0; rv_pct = 100; rdy_pct = 100;
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic manual(input bit g, input bit rv, input bit rdy);
      auto_mem    = 0;
      imem_gnt    = g;
      imem_rvalid = rv;
      id_ready    = rdy;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; pc = 32'h0;
      manual(0, 0, 0);
      imem_rdata = 32'h0;

      // 1: reset holds everything idle, release starts fetching at pc 0
      step(); step();
      chk("t1_req_in_reset", 32'(last_req_obs), 32'd0);
      rst = 1'b1;
      step();
      chk("t1_req_after_release", 32'(last_req_obs), 32'd1);

      // 2: streaming, one instruction per cycle, first valid two cycles after first grant
      auto_mem = 1; gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
      seq_data = 1; seq_val = 32'h13; cyc = 0; first_valid_cyc = -1; pops = 0;
      for (int i = 0; i < 12; i++) step();
      chk("t2_first_valid_cyc", 32'(first_valid_cyc), 32'd2);
      chk("t2_pops", 32'(pops), 32'd10);
      chk("t2_last_pop_pc", last_pop_pc, 32'h24);
      seq_data = 0;
      drain();

      // 3: decode stalled -> exactly DEPTH grants, one pop reopens issue the cycle after
      auto_mem = 1; gnt_pct = 100; rv_pct = 100; rdy_pct = 0; grants_obs = 0;
      for (int i = 0; i < 8; i++) step();
      chk("t3_grants", 32'(grants_obs), 32'd4);
      rdy_pct = 100; step();
      chk("t3_req_in_pop_cycle", 32'(last_req_obs), 32'd0);
      rdy_pct = 0; step();
      chk("t3_req_after_pop", 32'(last_req_obs), 32'd1);
      drain();

      // 4: flush with two outstanding fetches drops both late responses
      manual(1, 0, 0); step(); step();
      manual(0, 0, 0); flush = 1'b1; redirect_pc = 32'h100; step();
      flush = 1'b0;
      manual(0, 1, 0); step();
      chk("t4_req_drop1", 32'(last_req_obs), 32'd0);
      step();
      chk("t4_req_drop2", 32'(last_req_obs), 32'd0);
      manual(0, 0, 0); step();
      chk("t4_req_resume", 32'(last_req_obs), 32'd1);
      auto_mem = 1; gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
      pops = 0; first_pop_pc = 32'hDEAD_BEEF;
      for (int i = 0; i < 20 && pops == 0; i++) step();
      chk("t4_first_pc", first_pop_pc, 32'h100);
      drain();

      // 5: flush coinciding with the last in-flight response and a head pop
      manual(1, 0, 0); step();
      manual(1, 1, 0); step();
      manual(0, 1, 1); flush = 1'b1; redirect_pc = 32'h200; step();
      flush = 1'b0;
      manual(0, 0, 0); step();
      chk("t5_req_next", 32'(last_req_obs), 32'd1);
      chk("t5_valid_next", 32'(last_valid_obs), 32'd0);
      auto_mem = 1; gnt_pct = 100; rv_pct = 100; rdy_pct = 100;
      pops = 0; first_pop_pc = 32'hDEAD_BEEF;
      for (int i = 0; i < 20 && pops == 0; i++) step();
      chk("t5_first_pc", first_pop_pc, 32'h200);
      drain();

      // 6: reset with three slots allocated, then a stray response is ignored
      manual(1, 0, 0); step(); step(); step();
      manual(0, 0, 0); rst = 1'b0; step();
      rst = 1'b1; manual(0, 1, 0); step();
      manual(0, 0, 0); step();
      chk("t6_valid_after_stray", 32'(last_valid_obs), 32'd0);
      step();
      chk("t6_valid_stays_low", 32'(last_valid_obs), 32'd0);

      // randomized traffic with occasional flushes and resets
      auto_mem = 1; gnt_pct = 70; rv_pct = 60; rdy_pct = 60; seq_data = 0;
      for (int i = 0; i < 1500; i++) begin
         flush       = ($urandom_range(99) < 3);
         rst         = ($urandom_range(199) != 0);
         redirect_pc = $urandom & 32'hFFFF_FFFC;
         step();
      end
      flush = 1'b0; rst = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
